// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: bus width, requester indices and arbiter state encoding.
package ebus_pkg;

  localparam int EBUS_WIDTH = 36;

  localparam int REQ_APR = 0;
  localparam int REQ_CON = 1;
  localparam int REQ_CRA = 2;
  localparam int REQ_CTL = 3;
  localparam int REQ_EDP = 4;
  localparam int REQ_IR  = 5;
  localparam int REQ_PI  = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } tEbusState;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: first set request strictly above
// lastGrant, wrapping modulo NREQ. Returns one-hot, index and a found flag.
module rr_pick #(
  parameter int NREQ = 7
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] lastGrant,
  output logic [NREQ-1:0]         pick,
  output logic [$clog2(NREQ)-1:0] pickIdx,
  output logic                    pickValid
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    int j;
    j         = 0;
    pick      = '0;
    pickIdx   = '0;
    pickValid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(lastGrant) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pickValid && req[j]) begin
        pick[j]   = 1'b1;
        pickIdx   = IW'(j);
        pickValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS arbiter: rotating-priority grant, fixed setup/hold transfer timeline.
// Optional sticky parity checker enabled by defining EBUS_PARITY_CHECK_EN.
module ebus_arbiter
  import ebus_pkg::*;
#(
  parameter int NREQ         = 7,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                            eboxClk,
  input  logic                            eboxReset,
  input  logic [NREQ-1:0]                 reqIn,
  input  logic [NREQ-1:0][EBUS_WIDTH-1:0] reqData,
  input  logic [NREQ-1:0]                 reqParity,
  output logic [NREQ-1:0]                 grant,
  output logic [EBUS_WIDTH-1:0]           ebusData,
  output logic                            ebusParity,
  output logic                            ebusValid,
  output logic                            xferDone,
  output logic                            xferAbort,
  output logic                            busy
`ifdef EBUS_PARITY_CHECK_EN
  ,
  output logic                            parityErr
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam logic [2:0] SETUP_INIT = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] HOLD_INIT  = 3'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 7) begin : gBadSetup
    $error("ebus_arbiter: SETUP_CYCLES must be in 1..7");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 7) begin : gBadHold
    $error("ebus_arbiter: HOLD_CYCLES must be in 1..7");
  end

  tEbusState       state;
  logic [IW-1:0]   lastGrant;
  logic [2:0]      count;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pickIdx;
  logic            pickValid;

  rr_pick #(.NREQ(NREQ)) uPick (
    .req      (reqIn),
    .lastGrant(lastGrant),
    .pick     (pick),
    .pickIdx  (pickIdx),
    .pickValid(pickValid)
  );

  assign busy = (state != IDLE);

  // lastGrant always names the current owner outside IDLE, so it doubles as the
  // index of the granted requester during SETUP.
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state      <= IDLE;
      lastGrant  <= IW'(NREQ - 1);
      count      <= '0;
      grant      <= '0;
      ebusData   <= '0;
      ebusParity <= 1'b0;
      ebusValid  <= 1'b0;
      xferDone   <= 1'b0;
      xferAbort  <= 1'b0;
    end else begin
      xferDone  <= 1'b0;
      xferAbort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pickValid) begin
            grant     <= pick;
            lastGrant <= pickIdx;
            count     <= SETUP_INIT;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (!reqIn[lastGrant]) begin
            grant     <= '0;
            xferAbort <= 1'b1;
            state     <= RELEASE;
          end else if (count == 3'd0) begin
            ebusData   <= reqData[lastGrant];
            ebusParity <= reqParity[lastGrant];
            ebusValid  <= 1'b1;
            count      <= HOLD_INIT;
            xferDone   <= (HOLD_INIT == 3'd0);
            state      <= XFER;
          end else begin
            count <= count - 3'd1;
          end
        end
        XFER: begin
          if (count == 3'd0) begin
            grant      <= '0;
            ebusData   <= '0;
            ebusParity <= 1'b0;
            ebusValid  <= 1'b0;
            state      <= RELEASE;
          end else begin
            count    <= count - 3'd1;
            xferDone <= (count == 3'd1);
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef EBUS_PARITY_CHECK_EN
  logic firstXfer;

  // firstXfer marks the cycle right after the data latch; XNOR-reduce gives
  // the parity bit that makes the 37-bit word odd.
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      firstXfer <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      firstXfer <= (state == SETUP) && reqIn[lastGrant] && (count == 3'd0);
      if (firstXfer && ((~^ebusData) != ebusParity)) parityErr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ebus_arbiter.sv
// Directed bench for ebus_arbiter: default (S=1,H=2), S=7/H=7 and H=1 instances.
module tb_ebus_arbiter;
  import ebus_pkg::*;

  localparam int NREQ = 7;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] reqInA, reqInB, reqInC;
  logic [NREQ-1:0][EBUS_WIDTH-1:0] reqData;
  logic [NREQ-1:0] reqParity;
  logic [EBUS_WIDTH-1:0] expData [NREQ];

  logic [NREQ-1:0] grantA, grantB, grantC;
  logic [EBUS_WIDTH-1:0] dataA, dataB, dataC;
  logic parA, parB, parC, validA, validB, validC;
  logic doneA, doneB, doneC, abortA, abortB, abortC, busyA, busyB, busyC;
`ifdef EBUS_PARITY_CHECK_EN
  logic perrA, perrB, perrC;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ebus_arbiter #(.NREQ(NREQ), .SETUP_CYCLES(1), .HOLD_CYCLES(2)) dutA (
    .eboxClk(clk), .eboxReset(rst), .reqIn(reqInA), .reqData(reqData), .reqParity(reqParity),
    .grant(grantA), .ebusData(dataA), .ebusParity(parA), .ebusValid(validA),
    .xferDone(doneA), .xferAbort(abortA), .busy(busyA)
`ifdef EBUS_PARITY_CHECK_EN
    , .parityErr(perrA)
`endif
  );

  ebus_arbiter #(.NREQ(NREQ), .SETUP_CYCLES(7), .HOLD_CYCLES(7)) dutB (
    .eboxClk(clk), .eboxReset(rst), .reqIn(reqInB), .reqData(reqData), .reqParity(reqParity),
    .grant(grantB), .ebusData(dataB), .ebusParity(parB), .ebusValid(validB),
    .xferDone(doneB), .xferAbort(abortB), .busy(busyB)
`ifdef EBUS_PARITY_CHECK_EN
    , .parityErr(perrB)
`endif
  );

  ebus_arbiter #(.NREQ(NREQ), .SETUP_CYCLES(1), .HOLD_CYCLES(1)) dutC (
    .eboxClk(clk), .eboxReset(rst), .reqIn(reqInC), .reqData(reqData), .reqParity(reqParity),
    .grant(grantC), .ebusData(dataC), .ebusParity(parC), .ebusValid(validC),
    .xferDone(doneC), .xferAbort(abortC), .busy(busyC)
`ifdef EBUS_PARITY_CHECK_EN
    , .parityErr(perrC)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleA(input string tag);
    check({tag, "_grant"}, 64'(grantA), 64'd0);
    check({tag, "_data"}, 64'(dataA), 64'd0);
    check({tag, "_valid"}, 64'(validA), 64'd0);
    check({tag, "_done"}, 64'(doneA), 64'd0);
    check({tag, "_busy"}, 64'(busyA), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    expData[0] = 36'o777000111222;
    expData[1] = 36'o000000000001;
    expData[2] = 36'o123456701234;
    expData[3] = 36'o000000000000;
    expData[4] = 36'o444444444444;
    expData[5] = 36'o525252525252;
    expData[6] = 36'o012345670123;
    for (int i = 0; i < NREQ; i++) begin
      reqData[i]   = expData[i];
      reqParity[i] = ~^expData[i];
    end
    reqParity[2] = 1'b1;
    reqParity[3] = 1'b0;
    reqInA = '0; reqInB = '0; reqInC = '0;

    rst = 1'b1;
    #1;
    checkIdleA("reset");
    check("reset_abort", 64'(abortA), 64'd0);
    check("reset_parity", 64'(parA), 64'd0);
    step();
    rst = 1'b0;

    // Single CRA request.
    reqInA = 7'b0000100;
    step();
    check("single_c1_grant", 64'(grantA), 64'b0000100);
    check("single_c1_valid", 64'(validA), 64'd0);
    check("single_c1_busy", 64'(busyA), 64'd1);
    step();
    check("single_c2_grant", 64'(grantA), 64'b0000100);
    check("single_c2_valid", 64'(validA), 64'd1);
    check("single_c2_data", 64'(dataA), 64'(36'o123456701234));
    check("single_c2_parity", 64'(parA), 64'd1);
    check("single_c2_done", 64'(doneA), 64'd0);
    step();
    check("single_c3_grant", 64'(grantA), 64'b0000100);
    check("single_c3_valid", 64'(validA), 64'd1);
    check("single_c3_done", 64'(doneA), 64'd1);
    reqInA = '0;
    step();
    check("single_c4_grant", 64'(grantA), 64'd0);
    check("single_c4_data", 64'(dataA), 64'd0);
    check("single_c4_valid", 64'(validA), 64'd0);
    check("single_c4_done", 64'(doneA), 64'd0);
    check("single_c4_busy", 64'(busyA), 64'd1);
    step();
    check("single_c5_busy", 64'(busyA), 64'd0);

    // Rotation with every request held.
    rst = 1'b1;
    step();
    rst = 1'b0;
    reqInA = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rot_grant", 64'(grantA), 64'(7'b1 << (i % 7)));
      step();
      check("rot_data", 64'(dataA), 64'(expData[i % 7]));
      check("rot_onehot", 64'($onehot0(grantA)), 64'd1);
      step();
      check("rot_done", 64'(doneA), 64'd1);
      step();
      check("rot_release", 64'(grantA), 64'd0);
      if (i < 7) begin
        step();
        check("rot_idle", 64'(busyA), 64'd0);
      end
    end
    reqInA = '0;

    // EDP aborts in SETUP; rotation continues above index 4.
    rst = 1'b1;
    step();
    rst = 1'b0;
    reqInA = 7'b0010000;
    step();
    check("abort_grant", 64'(grantA), 64'b0010000);
    reqInA = '0;
    step();
    check("abort_pulse", 64'(abortA), 64'd1);
    check("abort_grant0", 64'(grantA), 64'd0);
    check("abort_valid", 64'(validA), 64'd0);
    check("abort_done", 64'(doneA), 64'd0);
    reqInA = 7'b0100001;
    step();
    check("abort_pulse_end", 64'(abortA), 64'd0);
    check("abort_idle_valid", 64'(validA), 64'd0);
    step();
    check("abort_next_grant", 64'(grantA), 64'b0100000);
    step();
    check("midrst_valid", 64'(validA), 64'd1);

    // Reset in XFER clears everything at once.
    rst = 1'b1;
    #1;
    checkIdleA("midrst");
    check("midrst_abort", 64'(abortA), 64'd0);
    reqInA = 7'b1000000;
    step();
    rst = 1'b0;
    step();
    check("midrst_pi_grant", 64'(grantA), 64'b1000000);
    rst = 1'b1;
    step();
    reqInA = '1;
    rst = 1'b0;
    step();
    check("rst_all_grant", 64'(grantA), 64'b0000001);
    reqInA = '0;

    // Zero data with even parity bit: a parity violation.
    rst = 1'b1;
    #1;
`ifdef EBUS_PARITY_CHECK_EN
    check("perr_reset", 64'(perrA), 64'd0);
`endif
    step();
    rst = 1'b0;
    reqInA = 7'b0001000;
    step();
    check("par_grant", 64'(grantA), 64'b0001000);
    step();
    check("par_valid", 64'(validA), 64'd1);
    check("par_data", 64'(dataA), 64'd0);
    check("par_parity", 64'(parA), 64'd0);
    step();
    check("par_done", 64'(doneA), 64'd1);
`ifdef EBUS_PARITY_CHECK_EN
    check("perr_set", 64'(perrA), 64'd1);
`endif
    reqInA = '0;
    step();
    step();
    reqInA = 7'b0100000;
    step();
    step();
    check("par_good_parity", 64'(parA), 64'(~^expData[5]));
    step();
    check("par_good_done", 64'(doneA), 64'd1);
    reqInA = '0;
    step();
    step();
`ifdef EBUS_PARITY_CHECK_EN
    check("perr_sticky", 64'(perrA), 64'd1);
`endif

    // S=7, H=7: grant 1..14, valid 8..14, done at 14.
    reqInB = 7'b0000001;
    for (int c = 1; c <= 15; c++) begin
      step();
      check("s7_grant", 64'(grantB), (c <= 14) ? 64'd1 : 64'd0);
      check("s7_valid", 64'(validB), (c >= 8 && c <= 14) ? 64'd1 : 64'd0);
      check("s7_done", 64'(doneB), (c == 14) ? 64'd1 : 64'd0);
      if (c == 8) check("s7_data", 64'(dataB), 64'(expData[0]));
      if (c == 14) reqInB = '0;
    end

    // H=1: valid and done in the same single cycle.
    reqInC = 7'b0000001;
    step();
    check("h1_c1_grant", 64'(grantC), 64'd1);
    check("h1_c1_valid", 64'(validC), 64'd0);
    step();
    check("h1_c2_valid", 64'(validC), 64'd1);
    check("h1_c2_done", 64'(doneC), 64'd1);
    check("h1_c2_data", 64'(dataC), 64'(expData[0]));
    reqInC = '0;
    step();
    check("h1_c3_valid", 64'(validC), 64'd0);
    check("h1_c3_done", 64'(doneC), 64'd0);
    check("h1_c3_grant", 64'(grantC), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
